wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Write-back commit stage between the execute/memory units and the 32-entry integer register file. It has two result sources:
- a single-cycle ALU path that can never stall;
- a long-latency LSU/MUL path that uses a valid/ready handshake and is buffered in a small in-order FIFO.

The stage merges both into the register file's single write port (write enable, rd, write data). It suppresses x0 writes and discards buffered long-latency results that a younger ALU write to the same register has overtaken.

## Interface
- XLEN, default 32: data width.
- DEPTH, default 4: long-latency result FIFO entries; power of two, at least 2.

- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- alu_valid  in  1: ALU result present this cycle; always accepted.
- alu_rd  in  5: ALU destination register.
- alu_data  in  XLEN: ALU result.
- lsu_valid  in  1: long-latency result offered.
- lsu_ready  out  1: FIFO can accept; a transfer occurs when lsu_valid and lsu_ready are both 1.
- lsu_rd  in  5: long-latency destination register.
- lsu_data  in  XLEN: long-latency result.
- reg_write_en  out  1: register file write enable, registered.
- rd  out  5: register file write address, registered.
- write_data  out  XLEN: register file write data, registered.
- pending_mask  out  32: bit i is 1 while a live, non-killed FIFO entry targets xi (see Configuration).

## Operation
- FIFO entry fields: rd, data, kill flag. The stage keeps count, head pointer and tail pointer; pointers wrap modulo DEPTH.
- lsu_ready = (count < DEPTH). A pop in the same cycle does not free a slot for that cycle's push.
- The write port has one slot per cycle. Priority, evaluated each cycle:
  - alu_valid=1: the ALU result owns the slot. reg_write_en_next = (alu_rd != 0). The FIFO does not drain.
  - alu_valid=0 and count>0: pop the head entry. reg_write_en_next = (head.rd != 0 and !head.kill).
  - Otherwise: reg_write_en_next = 0.
- rd/write_data load the winning source's rd/data whenever a source wins. Otherwise they hold their previous value.
- Kill rule: when alu_valid=1 and alu_rd != 0, every valid FIFO entry with rd == alu_rd has its kill flag set. This includes an entry pushed in the same cycle, because the ALU result is defined as younger.
- A killed entry still pops in a drain cycle, with no write. The LSU producer sees no indication.
- Push and pop in the same cycle: count is unchanged. When count==DEPTH, no push occurs.
- Writes to x0 never assert reg_write_en, but they still consume their slot and their FIFO entry.

## Timing
- ALU result accepted in cycle N: write port asserted in cycle N+1; the register file captures it at the end of N+1.
- LSU result pushed in cycle N: earliest pop is N+1 (with alu_valid=0 in N+1); write port asserted in N+2.
- Each consecutive cycle with alu_valid=1 delays the drain by one cycle. There is no starvation guard; the ALU has strict priority.
- Reset, asynchronous:
  - reg_write_en=0, rd=0, write_data=0;
  - FIFO emptied with count=0, all kill flags cleared;
  - pending_mask=0;
  - lsu_ready=0 while rst=1, and 1 from the first cycle after release.
- Reset in mid-operation discards all queued results, and no write is issued for them.
- lsu_valid/lsu_rd/lsu_data must stay stable while lsu_valid=1 and lsu_ready=0. The stage does not check this.

## Configuration
- WB_PENDING_MASK_EN defined: pending_mask is driven combinationally from the FIFO contents. A bit is set for each valid, non-killed entry rd, except bit 0, which is always 0. This lets the issue logic stall readers of registers with pending writes.
- WB_PENDING_MASK_EN undefined: pending_mask is tied to 0. No mask logic is synthesised, and all other behaviour is identical.

## Test plan
- ALU only:
  - alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle N -> cycle N+1 shows reg_write_en=1, rd=5, write_data=0xDEADBEEF.
  - Same with alu_rd=0 -> reg_write_en=0.
- LSU drain:
  - Push lsu_rd=7, data=0x1234 in cycle N; alu_valid=0 from then on -> write of x7=0x1234 appears in cycle N+2.
- Priority and fill:
  - Hold alu_valid=1 while pushing 4 LSU results to x1..x4 -> lsu_ready=0 after the 4th push.
  - Drop alu_valid -> writes x1, x2, x3, x4 appear in order on 4 consecutive cycles, and lsu_ready returns to 1.
- Kill:
  - Push lsu_rd=9, data=0xAAAA; next cycle alu_valid=1, alu_rd=9, data=0xBBBB -> only x9=0xBBBB is written.
  - The drain cycle for 0xAAAA shows reg_write_en=0.
- Simultaneous kill: lsu push to rd=3 and alu_valid to rd=3 in the same cycle -> x3 gets the ALU data; the LSU entry is killed.
- Reset mid-operation and mask:
  - With 3 entries queued, pulse rst asynchronously between clock edges -> all outputs go to 0 immediately, and no queued write ever appears.
  - With WB_PENDING_MASK_EN, pending_mask = 0x0000_0086 for queued x1, x2, x7 before the reset, and 0 after it.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back commit stage: merges the never-stalling ALU path and the FIFO-buffered
// LSU/MUL path onto the single register-file write port. Optional WB_PENDING_MASK_EN.
module wb_commit_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            reg_write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending_mask
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [DEPTH-1:0] fifo_kill;
  logic [DEPTH-1:0] kill_hit;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic alu_kill_en;
  logic do_push;
  logic do_pop;
  logic head_live;

  assign alu_kill_en = alu_valid && (alu_rd != 5'd0);
  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign lsu_ready   = !rst && (count < CNT_FULL);
  assign do_push     = lsu_valid && (count < CNT_FULL);
  assign do_pop      = !alu_valid && (count != '0);
  assign head_live   = (fifo_rd[head] != 5'd0) && !fifo_kill[head];

  always_comb begin
    kill_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_kill_en && fifo_vld[PW'(i)] && (fifo_rd[PW'(i)] == alu_rd))
        kill_hit[PW'(i)] = 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by fifo_vld and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_rd[tail]   <= lsu_rd;
      fifo_data[tail] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fifo_vld     <= '0;
      fifo_kill    <= '0;
      reg_write_en <= 1'b0;
      rd           <= '0;
      write_data   <= '0;
    end else begin
      fifo_kill <= fifo_kill | kill_hit;

      // The pushed entry is older than a same-cycle ALU result, so it can be killed at once.
      if (do_push) begin
        fifo_vld[tail]  <= 1'b1;
        fifo_kill[tail] <= alu_kill_en && (lsu_rd == alu_rd);
        tail            <= tail + 1'b1;
      end

      if (do_pop) begin
        fifo_vld[head] <= 1'b0;
        head           <= head + 1'b1;
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (alu_valid) begin
        reg_write_en <= (alu_rd != 5'd0);
        rd           <= alu_rd;
        write_data   <= alu_data;
      end else if (do_pop) begin
        reg_write_en <= head_live;
        rd           <= fifo_rd[head];
        write_data   <= fifo_data[head];
      end else begin
        reg_write_en <= 1'b0;
      end
    end
  end

`ifdef WB_PENDING_MASK_EN
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[PW'(i)] && !fifo_kill[PW'(i)])
        pending_mask[fifo_rd[PW'(i)]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end
`else
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed plan steps plus randomized traffic
// checked against a queue-based model of the commit rules.
module tb_wb_commit_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            reg_write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pending_mask;

  wb_commit_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .reg_write_en (reg_write_en),
    .rd           (rd),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          total = 0;
  int          bad   = 0;

`ifdef WB_PENDING_MASK_EN
  localparam logic [31:0] MASK_X1_X2_X7 = 32'h0000_0086;
`else
  localparam logic [31:0] MASK_X1_X2_X7 = 32'h0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
`ifdef WB_PENDING_MASK_EN
    foreach (q[k]) if (!q[k].kill && q[k].rd != 5'd0) m[q[k].rd] = 1'b1;
`endif
    return m;
  endfunction

  // One clock cycle: check pre-edge state, drive inputs, advance model, check write port.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit   exp_ready;
    ent_t e;
    exp_ready = (q.size() < DEPTH);
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, exp_ready});
    chk("pending_mask", {32'd0, pending_mask}, {32'd0, model_mask()});
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;

    m_we = 1'b0;
    if (av) begin
      m_we = (ard != 5'd0); m_rd = ard; m_data = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = (e.rd != 5'd0) && !e.kill; m_rd = e.rd; m_data = e.data;
    end
    if (lv && exp_ready) q.push_back('{rd: lrd, data: ld, kill: 1'b0});
    if (av && ard != 5'd0) foreach (q[k]) if (q[k].rd == ard) q[k].kill = 1'b1;

    @(posedge clk); #1;
    chk("reg_write_en", {63'd0, reg_write_en}, {63'd0, m_we});
    chk("rd", {59'd0, rd}, {59'd0, m_rd});
    chk("write_data", {32'd0, write_data}, {32'd0, m_data});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic        lv_n;
    logic        lv_hold;
    logic [4:0]  lrd_n;
    logic [31:0] ld_n;
    logic        av_n;
    logic [4:0]  ard_n;
    bit          acc;

    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    m_we = 1'b0; m_rd = '0; m_data = '0;
    #2;
    chk("rst_we", {63'd0, reg_write_en}, 64'd0);
    chk("rst_rd", {59'd0, rd}, 64'd0);
    chk("rst_data", {32'd0, write_data}, 64'd0);
    chk("rst_ready", {63'd0, lsu_ready}, 64'd0);
    chk("rst_mask", {32'd0, pending_mask}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU only, including an x0 write
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    chk("alu_x5_data", {32'd0, write_data}, 64'hDEAD_BEEF);
    cycle(1'b1, 5'd0, 32'h1111_2222, 1'b0, 5'd0, 32'd0);
    chk("alu_x0_we", {63'd0, reg_write_en}, 64'd0);

    // LSU drain: pushed in N, written in N+2
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_1234);
    idle(1);
    chk("lsu_x7_we", {63'd0, reg_write_en}, 64'd1);
    chk("lsu_x7_data", {32'd0, write_data}, 64'h1234);
    idle(1);

    // Fill under ALU priority, then drain in order
    for (int unsigned i = 1; i <= 4; i++)
      cycle(1'b1, 5'(19 + i), 32'hA000_0000 + i, 1'b1, 5'(i), 32'hC000_0000 + i);
    chk("full_ready", {63'd0, lsu_ready}, 64'd0);
    for (int unsigned i = 1; i <= 4; i++) begin
      idle(1);
      chk("drain_order", {59'd0, rd}, 64'(i));
    end
    idle(2);

    // Kill by a younger ALU write
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_AAAA);
    cycle(1'b1, 5'd9, 32'h0000_BBBB, 1'b0, 5'd0, 32'd0);
    idle(1);
    chk("killed_drain_we", {63'd0, reg_write_en}, 64'd0);
    idle(1);

    // Simultaneous push and ALU write to the same register
    cycle(1'b1, 5'd3, 32'h0000_3A3A, 1'b1, 5'd3, 32'h0000_3C3C);
    idle(3);

    // Reset mid-operation with x1, x2, x7 queued
    cycle(1'b1, 5'd10, 32'h5555_0001, 1'b1, 5'd1, 32'h0000_0101);
    cycle(1'b1, 5'd10, 32'h5555_0002, 1'b1, 5'd2, 32'h0000_0202);
    cycle(1'b1, 5'd10, 32'h5555_0003, 1'b1, 5'd7, 32'h0000_0707);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("mask_queued", {32'd0, pending_mask}, {32'd0, MASK_X1_X2_X7});
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {63'd0, reg_write_en}, 64'd0);
    chk("arst_rd", {59'd0, rd}, 64'd0);
    chk("arst_data", {32'd0, write_data}, 64'd0);
    chk("arst_ready", {63'd0, lsu_ready}, 64'd0);
    chk("arst_mask", {32'd0, pending_mask}, 64'd0);
    q.delete(); m_we = 1'b0; m_rd = '0; m_data = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle(6);

    // Randomized traffic with a protocol-respecting LSU producer
    lv_hold = 1'b0; lv_n = 1'b0; lrd_n = '0; ld_n = '0;
    for (int unsigned n = 0; n < 400; n++) begin
      if (!lv_hold) begin
        lv_n  = ($urandom_range(0, 9) < 6);
        lrd_n = 5'($urandom_range(0, 7));
        ld_n  = $urandom;
      end
      av_n  = ($urandom_range(0, 9) < 4);
      ard_n = 5'($urandom_range(0, 7));
      acc   = lv_n && (q.size() < DEPTH);
      cycle(av_n, ard_n, $urandom, lv_n, lrd_n, ld_n);
      lv_hold = lv_n && !acc;
    end
    idle(DEPTH + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
